// File: rtl/tt_sweep_pkg.sv
// Shared types and helpers for the truth-table sweep checker.
// Optional feature macro: TT_SWEEP_FAIL_MASK_EN (adds a per-vector fail mask).
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Widest truth table the expected-bit helper accepts (N_IN up to 10).
  localparam int MAX_TT_W = 1024;

  // Number of input vectors for an n_in-input netlist.
  function automatic int n_vec_of(input int n_in);
    return 1 << n_in;
  endfunction

  // Counter width able to hold 0..max_val, never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // Expected netlist output for vector idx: vector 0 maps to the TT MSB.
  function automatic logic exp_bit(input logic [MAX_TT_W-1:0] tt,
                                   input logic [31:0]         idx,
                                   input logic [31:0]         n_vec);
    logic [MAX_TT_W-1:0] sh;
    sh = tt >> (n_vec - 32'd1 - idx);
    return sh[0];
  endfunction

endpackage

// File: rtl/tt_sweep_checker_if.sv
// Control, netlist and result signals of the sweep checker.
// master = checker side, slave = environment / netlist side.
// Optional feature macro: TT_SWEEP_FAIL_MASK_EN (adds fail_mask).
interface tt_sweep_checker_if #(
  parameter int N_IN = 4
);
  logic            start;
  logic [N_IN-1:0] dut_in;
  logic            dut_out;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic            first_fail_valid;
  logic [N_IN-1:0] first_fail_idx;

`ifdef TT_SWEEP_FAIL_MASK_EN
  localparam int N_VEC = tt_sweep_pkg::n_vec_of(N_IN);
  logic [N_VEC-1:0] fail_mask;

  modport master (
    input  start, dut_out,
    output dut_in, busy, done, pass, err_count,
           first_fail_valid, first_fail_idx, fail_mask
  );

  modport slave (
    output start, dut_out,
    input  dut_in, busy, done, pass, err_count,
           first_fail_valid, first_fail_idx, fail_mask
  );
`else
  modport master (
    input  start, dut_out,
    output dut_in, busy, done, pass, err_count,
           first_fail_valid, first_fail_idx
  );

  modport slave (
    output start, dut_out,
    input  dut_in, busy, done, pass, err_count,
           first_fail_valid, first_fail_idx
  );
`endif

endinterface

// File: rtl/tt_sweep_timer.sv
// Settle timer: counts SETTLE+1 cycles per vector and flags the sample cycle.
// SETTLE=0 gives a tick on every enabled cycle.
module tt_sweep_timer
  import tt_sweep_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = cnt_width(SETTLE);

  logic [CNT_W-1:0] settle_cnt;

  assign tick = enable && (settle_cnt == CNT_W'(SETTLE));

  // Settle counter: restarts on clear and after each sample cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n || clear) begin
      settle_cnt <= '0;
    end else if (enable) begin
      settle_cnt <= tick ? '0 : settle_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tt_sweep_checker.sv
// Exhaustive truth-table sweep checker: drives every input vector in
// ascending order, waits SETTLE cycles, samples the netlist output and
// compares it with TT. Reports pass, error count and first failing vector.
// Optional feature macro: TT_SWEEP_FAIL_MASK_EN (per-vector fail mask).
module tt_sweep_checker
  import tt_sweep_pkg::*;
#(
  parameter int                    N_IN   = 4,
  parameter logic [(1<<N_IN)-1:0]  TT     = 16'h5215,
  parameter int                    SETTLE = 2
) (
  input logic                clk,
  input logic                rst_n,
  tt_sweep_checker_if.master bus
);

  localparam int                  N_VEC  = n_vec_of(N_IN);
  localparam logic [MAX_TT_W-1:0] TT_EXT = MAX_TT_W'(TT);

  state_t          state;
  logic [N_IN-1:0] vec;
  logic            busy_q;
  logic            done_q;
  logic            pass_q;
  logic [N_IN:0]   err_count_q;
  logic            ff_valid_q;
  logic [N_IN-1:0] ff_idx_q;
`ifdef TT_SWEEP_FAIL_MASK_EN
  logic [N_VEC-1:0] fail_mask_q;
`endif

  logic          sweep_start;
  logic          run_en;
  logic          tick;
  logic          exp_now;
  logic          mismatch;
  logic          last_vec;
  logic [N_IN:0] err_next;

  // A start is accepted only outside RUN; it also restarts the settle timer.
  assign sweep_start = (state != RUN) && bus.start;
  assign run_en      = (state == RUN);
  assign exp_now     = exp_bit(TT_EXT, 32'(vec), 32'(N_VEC));
  assign mismatch    = (bus.dut_out != exp_now);
  assign last_vec    = (vec == N_IN'(N_VEC - 1));
  // Error count including the current sample, so the final vector's result
  // reaches pass in the same edge that enters DONE.
  assign err_next    = err_count_q + {{N_IN{1'b0}}, mismatch};

  tt_sweep_timer #(
    .SETTLE (SETTLE)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (sweep_start),
    .enable (run_en),
    .tick   (tick)
  );

  // Sweep FSM, vector counter and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      vec         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= '0;
      ff_valid_q  <= 1'b0;
      ff_idx_q    <= '0;
`ifdef TT_SWEEP_FAIL_MASK_EN
      fail_mask_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          vec    <= '0;
          busy_q <= 1'b0;
          if (bus.start) begin
            state       <= RUN;
            busy_q      <= 1'b1;
            pass_q      <= 1'b0;
            err_count_q <= '0;
            ff_valid_q  <= 1'b0;
            ff_idx_q    <= '0;
`ifdef TT_SWEEP_FAIL_MASK_EN
            fail_mask_q <= '0;
`endif
          end else begin
            state <= IDLE;
          end
        end

        RUN: begin
          if (tick) begin
            err_count_q <= err_next;
            if (mismatch && !ff_valid_q) begin
              ff_valid_q <= 1'b1;
              ff_idx_q   <= vec;
            end
`ifdef TT_SWEEP_FAIL_MASK_EN
            // ~vec equals N_VEC-1-vec: same bit ordering as TT.
            if (mismatch) fail_mask_q[~vec] <= 1'b1;
`endif
            if (last_vec) begin
              state  <= DONE;
              vec    <= '0;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              pass_q <= (err_next == '0);
            end else begin
              vec <= vec + 1'b1;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.dut_in           = vec;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.pass             = pass_q;
  assign bus.err_count        = err_count_q;
  assign bus.first_fail_valid = ff_valid_q;
  assign bus.first_fail_idx   = ff_idx_q;
`ifdef TT_SWEEP_FAIL_MASK_EN
  assign bus.fail_mask        = fail_mask_q;
`endif

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Bench for tt_sweep_checker: two instances (SETTLE=2 and SETTLE=0) drive a
// modelled 0x5215 netlist with injectable per-vector faults; results are
// compared with a reference computed from the fault pattern.
// Optional feature macro: TT_SWEEP_FAIL_MASK_EN (fail_mask also checked).
module tb_tt_sweep_checker;

  localparam int          N_IN  = 4;
  localparam int          N_VEC = 16;
  localparam logic [15:0] TT_C  = 16'h5215;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tt_sweep_checker_if #(.N_IN(N_IN)) b0 ();
  tt_sweep_checker_if #(.N_IN(N_IN)) b1 ();

  tt_sweep_checker #(.N_IN(N_IN), .TT(TT_C), .SETTLE(2)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b0)
  );

  tt_sweep_checker #(.N_IN(N_IN), .TT(TT_C), .SETTLE(0)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1)
  );

  // Fault pattern: bit i set means the netlist answers wrongly on vector i.
  logic [15:0] flip0 = '0;
  logic [15:0] flip1 = '0;
  logic        start0 = 1'b0;
  logic        start1 = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference truth table: vector i maps to TT bit 15-i.
  function automatic logic tt_ref(input logic [3:0] i);
    logic [15:0] t;
    t = TT_C >> (4'd15 - i);
    return t[0];
  endfunction

  assign b0.start   = start0;
  assign b1.start   = start1;
  assign b0.dut_out = tt_ref(b0.dut_in) ^ flip0[b0.dut_in];
  assign b1.dut_out = tt_ref(b1.dut_in) ^ flip1[b1.dut_in];

  typedef struct {
    logic        busy;
    logic        done;
    logic        pass;
    logic        ffv;
    logic [4:0]  err;
    logic [3:0]  ffi;
    logic [3:0]  din;
    logic [15:0] mask;
  } snap_t;

  function automatic snap_t snap(input int which);
    snap_t s;
    s.busy = (which == 1) ? b1.busy             : b0.busy;
    s.done = (which == 1) ? b1.done             : b0.done;
    s.pass = (which == 1) ? b1.pass             : b0.pass;
    s.ffv  = (which == 1) ? b1.first_fail_valid : b0.first_fail_valid;
    s.err  = (which == 1) ? b1.err_count        : b0.err_count;
    s.ffi  = (which == 1) ? b1.first_fail_idx   : b0.first_fail_idx;
    s.din  = (which == 1) ? b1.dut_in           : b0.dut_in;
`ifdef TT_SWEEP_FAIL_MASK_EN
    s.mask = (which == 1) ? b1.fail_mask        : b0.fail_mask;
`else
    s.mask = '0;
`endif
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // One-cycle start pulse; returns at the first busy-cycle sample point.
  task automatic start_pulse(input int which);
    @(negedge clk);
    if (which == 1) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    if (which == 1) start1 = 1'b0; else start0 = 1'b0;
  endtask

  // Follows a sweep from its first busy cycle up to the done cycle and checks
  // timing, vector order and results against the fault-pattern reference.
  task automatic observe(input int which, input logic [15:0] f, input int settle,
                         input string tag);
    int          exp_err;
    int          exp_first;
    bit          found;
    logic [15:0] exp_mask;
    int          busy_cnt;
    int          order_err;
    bit          got_done;
    snap_t       s;

    exp_err = 0; exp_first = 0; found = 0; exp_mask = '0;
    for (int i = 0; i < N_VEC; i++) begin
      if (f[i]) begin
        exp_err++;
        if (!found) begin exp_first = i; found = 1; end
        exp_mask[15 - i] = 1'b1;
      end
    end

    busy_cnt = 0; order_err = 0; got_done = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      s = snap(which);
      if (s.done) begin got_done = 1; break; end
      if (s.busy) begin
        if (int'(s.din) != busy_cnt / (settle + 1)) order_err++;
        busy_cnt++;
      end else begin
        order_err++;
      end
      @(negedge clk);
    end

    check({tag, "_done_seen"},   32'(got_done), 32'd1);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(N_VEC * (settle + 1)));
    check({tag, "_vec_order"},   32'(order_err), 32'd0);
    check({tag, "_busy_at_done"}, 32'(s.busy), 32'd0);
    check({tag, "_din_at_done"}, 32'(s.din), 32'd0);
    check({tag, "_err_count"},   32'(s.err), 32'(exp_err));
    check({tag, "_pass"},        32'(s.pass), 32'(exp_err == 0));
    check({tag, "_ff_valid"},    32'(s.ffv), 32'(found));
    check({tag, "_ff_idx"},      32'(s.ffi), 32'(exp_first));
`ifdef TT_SWEEP_FAIL_MASK_EN
    check({tag, "_fail_mask"},   32'(s.mask), 32'(exp_mask));
`endif
  endtask

  // Hard stop if something wedges the stimulus.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    snap_t       s;
    logic [15:0] tied0;
    logic [15:0] fa;
    logic [15:0] fb;
    int          dn;
    int          bz;

    // Fault pattern that makes the netlist output constant 0.
    for (int i = 0; i < N_VEC; i++) tied0[i] = tt_ref(4'(i));

    // Reset state.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    s = snap(0);
    check("rst_busy", 32'(s.busy), 0);
    check("rst_done", 32'(s.done), 0);
    check("rst_pass", 32'(s.pass), 0);
    check("rst_err",  32'(s.err),  0);
    check("rst_ffv",  32'(s.ffv),  0);
    check("rst_ffi",  32'(s.ffi),  0);
    check("rst_din",  32'(s.din),  0);
    s = snap(1);
    check("rst1_busy", 32'(s.busy), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    s = snap(0);
    check("idle_busy", 32'(s.busy), 0);

    // 1: correct netlist, SETTLE=2.
    flip0 = '0;
    start_pulse(0);
    observe(0, flip0, 2, "t1");
    @(negedge clk);
    s = snap(0);
    check("t1_done_pulse_len", 32'(s.done), 0);
    check("t1_pass_hold",      32'(s.pass), 1);

    // 2: netlist output tied to 0.
    flip0 = tied0;
    start_pulse(0);
    observe(0, flip0, 2, "t2");
    s = snap(0);
    check("t2_err_6",  32'(s.err), 6);
    check("t2_ffi_1",  32'(s.ffi), 1);
`ifdef TT_SWEEP_FAIL_MASK_EN
    check("t2_mask_tt", 32'(s.mask), 32'h5215);
`endif

    // 3: inverted netlist output.
    flip0 = 16'hFFFF;
    start_pulse(0);
    observe(0, flip0, 2, "t3");
    s = snap(0);
    check("t3_err_16", 32'(s.err), 16);
    check("t3_ffi_0",  32'(s.ffi), 0);

    // 4: reset at busy-cycle 20 discards the partial sweep.
    flip0 = tied0;
    start_pulse(0);
    repeat (19) @(negedge clk);
    s = snap(0);
    check("t4_pre_err", 32'(s.err), 2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    s = snap(0);
    check("t4_busy", 32'(s.busy), 0);
    check("t4_din",  32'(s.din),  0);
    check("t4_err",  32'(s.err),  0);
    check("t4_ffv",  32'(s.ffv),  0);
    dn = 0; bz = 0;
    for (int c = 0; c < 60; c++) begin
      s = snap(0);
      if (s.done) dn++;
      if (s.busy) bz++;
      @(negedge clk);
    end
    check("t4_no_done", 32'(dn), 0);
    check("t4_no_busy", 32'(bz), 0);
    flip0 = '0;
    start_pulse(0);
    observe(0, flip0, 2, "t4b");

    // 5: start held high through a sweep, then back-to-back restart.
    fa = 16'($urandom) | 16'h0100;
    fb = 16'($urandom) & 16'($urandom);
    flip0 = fa;
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    observe(0, fa, 2, "t5a");
    @(negedge clk);
    s = snap(0);
    check("t5_restart_busy", 32'(s.busy), 1);
    check("t5_restart_din",  32'(s.din),  0);
    check("t5_restart_done", 32'(s.done), 0);
    check("t5_restart_err",  32'(s.err),  0);
    check("t5_restart_ffv",  32'(s.ffv),  0);
    check("t5_restart_pass", 32'(s.pass), 0);
`ifdef TT_SWEEP_FAIL_MASK_EN
    check("t5_restart_mask", 32'(s.mask), 0);
`endif
    start0 = 1'b0;
    flip0  = fb;
    observe(0, fb, 2, "t5b");

    // Randomized fault patterns, SETTLE=2.
    for (int k = 0; k < 6; k++) begin
      flip0 = (k % 2 == 0) ? 16'($urandom) : (16'($urandom) & 16'($urandom) & 16'($urandom));
      start_pulse(0);
      observe(0, flip0, 2, $sformatf("r0_%0d", k));
    end

    // 6: SETTLE=0, wrong only at vector 15.
    flip1 = 16'h8000;
    start_pulse(1);
    observe(1, flip1, 0, "t6");
    s = snap(1);
    check("t6_err_1",   32'(s.err), 1);
    check("t6_ffi_15",  32'(s.ffi), 15);
`ifdef TT_SWEEP_FAIL_MASK_EN
    check("t6_mask_1",  32'(s.mask), 32'h0001);
`endif

    // Randomized fault patterns, SETTLE=0.
    for (int k = 0; k < 4; k++) begin
      flip1 = 16'($urandom) & 16'($urandom);
      start_pulse(1);
      observe(1, flip1, 0, $sformatf("r1_%0d", k));
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
